// File: rtl/pc_sequencer.sv
// Program counter sequencer: picks the PC enable and next value each cycle, covering boot,
// sequential stepping, stalls and jump/branch redirects, and drives the front-end flushes.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
  parameter int          BOOT_CYCLES   = 2,
  parameter int          SHADOW_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  input  logic        stall_req,
  input  logic        imem_ready,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        pc_en,
  output logic [31:0] pc_next,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        redirect_pending,
  output logic [1:0]  state
);

  localparam int BW = $clog2(BOOT_CYCLES + 1);
  localparam int SW = $clog2(SHADOW_CYCLES + 1);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HOLD   = 2'd2,
    SHADOW = 2'd3
  } state_t;

  state_t          cur_state, next_state;
  logic [BW-1:0]   boot_cnt, boot_cnt_n;
  logic [SW-1:0]   shadow_cnt, shadow_cnt_n;
  logic            pend_valid, pend_valid_n;
  logic [31:0]     pend_target, pend_target_n;

  logic            stall;
  logic            redir;
  logic [31:0]     redir_target;
  logic [31:0]     pc_seq;

  assign stall        = stall_req | ~imem_ready;
  assign redir        = jump_valid | branch_taken;
  // The jump is the older instruction, so its target wins over a simultaneous branch.
  assign redir_target = jump_valid ? jump_target : branch_target;
  assign pc_seq       = pc_cur + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state   <= BOOT;
      boot_cnt    <= '0;
      shadow_cnt  <= '0;
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else begin
      cur_state   <= next_state;
      boot_cnt    <= boot_cnt_n;
      shadow_cnt  <= shadow_cnt_n;
      pend_valid  <= pend_valid_n;
      pend_target <= pend_target_n;
    end
  end

  always_comb begin
    next_state    = cur_state;
    boot_cnt_n    = boot_cnt;
    shadow_cnt_n  = shadow_cnt;
    pend_valid_n  = pend_valid;
    pend_target_n = pend_target;
    pc_en         = 1'b0;
    pc_next       = pc_cur;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;

    unique case (cur_state)
      BOOT: begin
        pc_en       = 1'b1;
        pc_next     = RESET_VECTOR;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        if (boot_cnt >= BW'(BOOT_CYCLES - 1)) begin
          next_state = RUN;
        end else begin
          boot_cnt_n = boot_cnt + BW'(1);
        end
      end

      RUN: begin
        if (redir && !stall) begin
          pc_en        = 1'b1;
          pc_next      = redir_target;
          flush_if_id  = 1'b1;
          flush_id_ex  = 1'b1;
          shadow_cnt_n = SW'(SHADOW_CYCLES);
          next_state   = SHADOW;
        end else if (redir) begin
          pend_valid_n  = 1'b1;
          pend_target_n = redir_target;
          next_state    = HOLD;
        end else if (!stall) begin
          pc_en   = 1'b1;
          pc_next = pc_seq;
        end
      end

      // The latched redirect is older than anything arriving now, so new redirects are dropped.
      HOLD: begin
        if (!stall) begin
          pc_en        = 1'b1;
          pc_next      = pend_target;
          flush_if_id  = 1'b1;
          flush_id_ex  = 1'b1;
          pend_valid_n = 1'b0;
          shadow_cnt_n = SW'(SHADOW_CYCLES);
          next_state   = SHADOW;
        end
      end

      SHADOW: begin
        if (!stall) begin
          pc_en        = 1'b1;
          pc_next      = pc_seq;
          shadow_cnt_n = shadow_cnt - SW'(1);
          if (shadow_cnt <= SW'(1)) begin
            shadow_cnt_n = '0;
            next_state   = RUN;
          end
        end
      end

      default: next_state = BOOT;
    endcase
  end

  assign redirect_pending = pend_valid;
  assign state            = cur_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a vector table plus hand-written HOLD/reset sequences,
// with expected outputs queued when each vector is driven and checked mid-cycle.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0040_0000;

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] pc;
    logic        stall;
    logic        ready;
    logic        jv;
    logic [31:0] jt;
    logic        bt;
    logic [31:0] btg;
    logic        en;
    logic [31:0] nxt;
    logic        fl;
    logic [1:0]  st;
    logic        pend;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_cur;
  logic        stall_req;
  logic        imem_ready;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        pc_en;
  logic [31:0] pc_next;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        redirect_pending;
  logic [1:0]  state;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  pc_sequencer #(
    .RESET_VECTOR (RV),
    .BOOT_CYCLES  (2),
    .SHADOW_CYCLES(2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_cur          (pc_cur),
    .stall_req       (stall_req),
    .imem_ready      (imem_ready),
    .jump_valid      (jump_valid),
    .jump_target     (jump_target),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .pc_en           (pc_en),
    .pc_next         (pc_next),
    .flush_if_id     (flush_if_id),
    .flush_id_ex     (flush_id_ex),
    .redirect_pending(redirect_pending),
    .state           (state)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string name, logic r, logic [31:0] pc, logic s, logic rdy,
                              logic jv, logic [31:0] jt, logic bt, logic [31:0] btg,
                              logic en, logic [31:0] nxt, logic fl, logic [1:0] st, logic pend);
    vec_t v;
    v.name = name; v.rst = r; v.pc = pc; v.stall = s; v.ready = rdy;
    v.jv = jv; v.jt = jt; v.bt = bt; v.btg = btg;
    v.en = en; v.nxt = nxt; v.fl = fl; v.st = st; v.pend = pend;
    return v;
  endfunction

  task automatic compare(string name, string field, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s.%s: got %h, expected %h", name, field, act, exp);
    end
  endtask

  task automatic applyStimulus(vec_t v);
    @(posedge clk);
    #1;
    rst           = v.rst;
    pc_cur        = v.pc;
    stall_req     = v.stall;
    imem_ready    = v.ready;
    jump_valid    = v.jv;
    jump_target   = v.jt;
    branch_taken  = v.bt;
    branch_target = v.btg;
    exp_q.push_back(v);
  endtask

  task automatic checkOutput();
    vec_t e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL scoreboard: got empty queue, expected a pending vector");
      return;
    end
    e = exp_q.pop_front();
    compare(e.name, "pc_en", {31'd0, pc_en}, {31'd0, e.en});
    compare(e.name, "pc_next", pc_next, e.nxt);
    compare(e.name, "flush_if_id", {31'd0, flush_if_id}, {31'd0, e.fl});
    compare(e.name, "flush_id_ex", {31'd0, flush_id_ex}, {31'd0, e.fl});
    compare(e.name, "state", {30'd0, state}, {30'd0, e.st});
    compare(e.name, "redirect_pending", {31'd0, redirect_pending}, {31'd0, e.pend});
  endtask

  task automatic applyVector(vec_t v);
    applyStimulus(v);
    checkOutput();
  endtask

  initial begin
    rst = 1'b1; pc_cur = '0; stall_req = 1'b0; imem_ready = 1'b1;
    jump_valid = 1'b0; jump_target = '0; branch_taken = 1'b0; branch_target = '0;

    //          name          rst pc            stl rdy jv jt           bt btg          en nxt           fl st pend
    tbl.push_back(mk("rst_hold",  1, 32'h0,        0, 1, 0, 32'h0,      0, 32'h0,      1, RV,           1, 0, 0));
    tbl.push_back(mk("boot0",     0, 32'hDEAD_BEEF,1, 1, 1, 32'h1234,   1, 32'h5678,   1, RV,           1, 0, 0));
    tbl.push_back(mk("boot1",     0, RV,           0, 1, 0, 32'h0,      0, 32'h0,      1, RV,           1, 0, 0));
    tbl.push_back(mk("run0",      0, RV,           0, 1, 0, 32'h0,      0, 32'h0,      1, RV + 32'h4,   0, 1, 0));
    tbl.push_back(mk("run1",      0, RV + 32'h4,   0, 1, 0, 32'h0,      0, 32'h0,      1, RV + 32'h8,   0, 1, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk("stall_req", 0, RV + 32'h8, 1, 1, 0, 32'h0,      0, 32'h0,      0, RV + 32'h8,   0, 1, 0));
    tbl.push_back(mk("stall_rel", 0, RV + 32'h8,   0, 1, 0, 32'h0,      0, 32'h0,      1, RV + 32'hC,   0, 1, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk("imem_wait", 0, RV + 32'hC, 0, 0, 0, 32'h0,      0, 32'h0,      0, RV + 32'hC,   0, 1, 0));
    tbl.push_back(mk("imem_rel",  0, RV + 32'hC,   0, 1, 0, 32'h0,      0, 32'h0,      1, RV + 32'h10,  0, 1, 0));
    tbl.push_back(mk("both_redir",0, RV + 32'h10,  0, 1, 1, 32'h1000,   1, 32'h2000,   1, 32'h1000,     1, 1, 0));
    tbl.push_back(mk("shadow0",   0, 32'h1000,     0, 1, 0, 32'h0,      1, 32'h2000,   1, 32'h1004,     0, 3, 0));
    tbl.push_back(mk("shadow_stl",0, 32'h1004,     1, 1, 0, 32'h0,      1, 32'h2000,   0, 32'h1004,     0, 3, 0));
    tbl.push_back(mk("shadow1",   0, 32'h1004,     0, 1, 0, 32'h0,      1, 32'h2000,   1, 32'h1008,     0, 3, 0));
    tbl.push_back(mk("post_shdw", 0, 32'h1008,     0, 1, 0, 32'h0,      1, 32'h40,     1, 32'h40,       1, 1, 0));
    tbl.push_back(mk("shadow2",   0, 32'h40,       0, 1, 0, 32'h0,      0, 32'h0,      1, 32'h44,       0, 3, 0));
    tbl.push_back(mk("shadow3",   0, 32'h44,       0, 1, 0, 32'h0,      0, 32'h0,      1, 32'h48,       0, 3, 0));
    tbl.push_back(mk("run2",      0, 32'h48,       0, 1, 0, 32'h0,      0, 32'h0,      1, 32'h4C,       0, 1, 0));

    foreach (tbl[i]) applyVector(tbl[i]);

    // Branch arrives during a stall: latched in HOLD, a younger jump is dropped, applied on release.
    applyVector(mk("hold_enter",  0, 32'h4C,       1, 1, 0, 32'h0,      1, 32'h80,     0, 32'h4C,       0, 1, 0));
    applyVector(mk("hold_jump",   0, 32'h4C,       1, 1, 1, 32'h900,    0, 32'h0,      0, 32'h4C,       0, 2, 1));
    applyVector(mk("hold_apply",  0, 32'h4C,       0, 1, 0, 32'h0,      0, 32'h0,      1, 32'h80,       1, 2, 1));
    applyVector(mk("hold_shdw0",  0, 32'h80,       0, 1, 0, 32'h0,      0, 32'h0,      1, 32'h84,       0, 3, 0));
    applyVector(mk("hold_shdw1",  0, 32'h84,       0, 1, 0, 32'h0,      0, 32'h0,      1, 32'h88,       0, 3, 0));
    applyVector(mk("wrap",        0, 32'hFFFF_FFFC,0, 1, 0, 32'h0,      0, 32'h0,      1, 32'h0,        0, 1, 0));

    // Reset while a redirect is held must discard it and reboot.
    applyVector(mk("rh_enter",    0, 32'h10,       0, 0, 1, 32'h500,    0, 32'h0,      0, 32'h10,       0, 1, 0));
    applyVector(mk("rh_reset",    1, 32'h10,       0, 0, 0, 32'h0,      0, 32'h0,      0, 32'h10,       0, 2, 1));
    applyVector(mk("rh_boot0",    0, 32'h10,       0, 1, 0, 32'h0,      0, 32'h0,      1, RV,           1, 0, 0));
    applyVector(mk("rh_boot1",    0, RV,           0, 1, 0, 32'h0,      0, 32'h0,      1, RV,           1, 0, 0));
    applyVector(mk("rh_run",      0, RV,           0, 1, 0, 32'h0,      0, 32'h0,      1, RV + 32'h4,   0, 1, 0));

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d leftover, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controller for the pipeline's program counter register.
- Drives the counter's enable and next-PC inputs every cycle: loads the reset vector on boot, steps sequentially, holds on stalls, and applies jump/branch redirects.
- Produces IF/ID and ID/EX flush strobes and suppresses redirects from squashed wrong-path instructions.
- Sits between hazard detection, EX-stage branch resolution and the program counter.

Parameters:
RESET_VECTOR, 32'h0000_0000, address loaded into PC after reset
BOOT_CYCLES, 2, cycles spent in BOOT forcing PC to RESET_VECTOR (>=1)
SHADOW_CYCLES, 2, cycles after a redirect during which redirect inputs are ignored (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
pc_cur  input  32  current PC value from program counter output
stall_req  input  1  hazard unit requests front-end hold
imem_ready  input  1  instruction memory can accept fetch; 0 acts as stall
jump_valid  input  1  jump resolved this cycle
jump_target  input  32  jump destination
branch_taken  input  1  taken branch resolved in EX this cycle
branch_target  input  32  branch destination
pc_en  output  1  program counter enable
pc_next  output  32  value to load into program counter
flush_if_id  output  1  squash IF/ID register
flush_id_ex  output  1  squash ID/EX register
redirect_pending  output  1  a redirect is latched awaiting stall release
state  output  2  BOOT=0, RUN=1, HOLD=2, SHADOW=3

Behaviour:
- Only clk and rst are used. Reset is synchronous and active-high: on a rising clk edge with rst=1, state<=BOOT, boot counter<=0, shadow counter<=0, pending valid/target<=0. Reset mid-operation (including in HOLD) discards the pending redirect.
- pc_en, pc_next and the flush outputs are combinational from state, counters and inputs, so they have zero latency into the PC. state and redirect_pending are registered.
- Define stall = stall_req | ~imem_ready.
- Define redir = jump_valid | branch_taken. If both are asserted, the jump wins and its target is used (the jump is the older instruction).
- Sequential PC is pc_cur + 4, truncated to 32 bits (wraps from 32'hFFFF_FFFC to 0). No alignment check is performed.
- BOOT:
  - pc_en=1, pc_next=RESET_VECTOR, flush_if_id=flush_id_ex=1. All inputs are ignored.
  - After BOOT_CYCLES cycles, go to RUN.
  - The PC has no reset of its own, so BOOT is what initialises it.
- RUN, in priority order:
  - redir & ~stall: pc_en=1, pc_next=target, both flushes=1, shadow counter<=SHADOW_CYCLES, go to SHADOW.
  - redir & stall: pc_en=0, latch the target, redirect_pending<=1, go to HOLD. No flush this cycle.
  - stall: pc_en=0, pc_next=pc_cur.
  - otherwise: pc_en=1, pc_next=pc_cur+4.
- HOLD:
  - While stalled: pc_en=0. New redir inputs are ignored, because the latched redirect is older and squashes them.
  - When stall drops: pc_en=1, pc_next=latched target, both flushes=1, clear pending, go to SHADOW with the counter loaded.
- SHADOW:
  - Redirect inputs are ignored and flushes are 0.
  - pc_en = ~stall; pc_next = stall ? pc_cur : pc_cur+4.
  - The counter decrements only on non-stalled cycles. When it reaches 0, go to RUN. The cycle after the last decrement already honours redirects.
- When pc_en=0, pc_next=pc_cur.
- Flushes are asserted only in BOOT and in redirect-apply cycles.
- redirect_pending is 1 exactly while in HOLD.

Test Plan:
- Reset: rst=1 for 1 cycle, then low, RESET_VECTOR=32'h0040_0000 → pc_en=1, pc_next=32'h0040_0000, flushes=1 for 2 cycles. In RUN with pc_cur=32'h0040_0000, pc_next=32'h0040_0004.
- Stall: stall_req=1 for 3 cycles in RUN → pc_en=0, pc_next=pc_cur for those cycles. Sequential stepping resumes the cycle stall drops. Repeat with imem_ready=0 and expect the same result.
- Simultaneous redirects: jump_valid=1 (32'h0000_1000) and branch_taken=1 (32'h0000_2000) in RUN → pc_next=32'h0000_1000, both flushes=1, state→SHADOW. A branch_taken during the next 2 unstalled cycles is ignored.
- Redirect during stall: branch_taken=1 (32'h0000_0080) with stall_req=1 → HOLD, redirect_pending=1, pc_en=0. A jump arriving while held is ignored. When stall drops, pc_next=32'h0000_0080 with flushes, and redirect_pending=0.
- Wrap and reset-in-HOLD: pc_cur=32'hFFFF_FFFC in RUN → pc_next=0. Asserting rst while in HOLD → next state BOOT, redirect_pending=0, and the latched target is never applied.
